matmul_mem_resp: RTL
====================

// Module: matmul_mem_resp
// PURPOSE
//  Memory responder (slave end) of the matmul memory bus: mem_req/mem_write/mem_addr/mem_wdata/mem_rdata.
//  Single-port word array; writes commit in the sampling cycle; reads return after a fixed RD_LAT.
//  A secondary preload port (ld_*) fills matrices A/B before go and yields to bus traffic.
//  Used as the on-chip scratch memory behind matmul and as the bench memory model.
// PARAMETERS
//  MEM_AW   16    bus address width
//  MEM_DW   32    data width
//  DEPTH    1024  implemented words; addresses >= DEPTH are out of range
//  RD_LAT   2     edges from request sampling to mem_rdata update; legal range 1..4
//  CNT_W    32    width of the activity counters
// PORTS
//  clk        in   1       clock; all logic on posedge
//  rst        in   1       synchronous reset, active-high
//  mem_req    in   1       request strobe; sampled every posedge, no back-pressure
//  mem_write  in   1       1 = write, 0 = read; qualified by mem_req
//  mem_addr   in   MEM_AW  word address
//  mem_wdata  in   MEM_DW  write data
//  mem_rdata  out  MEM_DW  read data; holds last value between reads
//  mem_rvalid out  1       1-cycle pulse, coincident with each mem_rdata update
//  ld_valid   in   1       preload request
//  ld_ready   out  1       combinational: ~(mem_req & mem_write); transfer = ld_valid & ld_ready
//  ld_addr    in   MEM_AW  preload address
//  ld_data    in   MEM_DW  preload data
//  err_oor    out  1       sticky: any out-of-range bus or preload access since reset
//  rd_count   out  CNT_W   accepted bus reads; saturates at all-ones
//  wr_count   out  CNT_W   accepted bus writes (in-range or not); saturates at all-ones
// BEHAVIOUR
//  Reset (sync): mem_rdata=0, mem_rvalid=0, err_oor=0, rd_count=0, wr_count=0; read pipe valids cleared.
//   Array contents are NOT cleared by rst.
//  Bus write (mem_req & mem_write at edge E): array[addr] <= wdata at E. A read sampled at E+1 sees the new data.
//  Bus read (mem_req & ~mem_write at edge E): stage 1 captures array[addr] and valid at E.
//   mem_rdata/mem_rvalid update at E+RD_LAT-1 (RD_LAT=2: update at E+1, visible the cycle after).
//   Matches matmul timing: request issued in cycle T is consumed by the initiator in cycle T+2.
//  Back-to-back reads: one per cycle, fully pipelined, returned in order, no bubbles.
//  Read and write are never simultaneous on the bus (single mem_write); no read/write hazard exists.
//  Preload: a transfer writes array[ld_addr] <= ld_data. A bus write in the same cycle wins; ld_ready=0.
//   A bus read plus a preload write in the same cycle are both accepted; the read returns pre-write data.
//  Out-of-range (addr >= DEPTH): writes and preloads are dropped; reads return 0 with normal rvalid timing.
//   In all three cases err_oor is set at the sampling edge.
//  Counters saturate and never wrap. rst mid-read discards pending reads; no rvalid is produced.
//  mem_req=0: no array access; mem_rdata holds its value; mem_rvalid=0.
//  No FSM: the read pipe is a shift register of {valid, data}, RD_LAT-1 stages after the array read.
// STRUCTURE
//  matmul_pkg: MEM_AW/MEM_DW defaults, RD_LAT_MIN=1 and RD_LAT_MAX=4, shared by matmul and the responder.
//  Sub-module mem_rd_pipe: parameterised valid+data delay line (DEPTH_STAGES=RD_LAT-1, sync clear on rst).
//  Top level: array, address-range check, preload arbitration, counters, err_oor.
// TESTING
//  1. Preload addr 0..3 = 1,2,3,4; bus reads of 0..3 back-to-back
//     -> rdata 1,2,3,4 in consecutive cycles; rvalid high for 4 cycles; rd_count=4.
//  2. Bus write addr 5 = 0xDEAD at E; read addr 5 at E+1 -> rdata=0xDEAD at E+RD_LAT; wr_count=1.
//  3. ld_valid with bus write in the same cycle -> ld_ready=0; preload lands the next cycle; bus data not overwritten.
//  4. Read addr DEPTH (1024) -> rdata=0 and rvalid pulse; err_oor=1 and stays 1 until rst.
//  5. Issue 2 reads, assert rst on the next edge -> no rvalid ever; outputs 0; earlier array contents still readable.
//  6. Closed loop with matmul: 2x2 A=[1 2;3 4], B=[5 6;7 8] -> memory C=[19 22;43 50]; ret pulses once.

Source files
------------

// File: rtl/matmul_mem_resp_pkg.sv
// Shared bus geometry and read-latency limits for matmul and its memory responder.
package matmul_mem_resp_pkg;

  localparam int MEM_AW_DEF = 16;
  localparam int MEM_DW_DEF = 32;
  localparam int DEPTH_DEF  = 1024;
  localparam int RD_LAT_DEF = 2;
  localparam int CNT_W_DEF  = 32;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Which port owns the single array write port in a given cycle.
  typedef enum logic [1:0] {
    WSRC_NONE = 2'd0,
    WSRC_BUS  = 2'd1,
    WSRC_LOAD = 2'd2
  } wsrc_e;

  function automatic int clamp_rd_lat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/matmul_mem_resp_rd_pipe.sv
// Valid+data delay line behind the array read; data only advances with a valid
// so the last stage holds the most recent read result.
module matmul_mem_resp_rd_pipe #(
  parameter int DW     = 32,
  parameter int STAGES = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign o_valid = i_valid;
      assign o_data  = i_data;
    end else begin : g_pipe
      logic          r_valid [STAGES];
      logic [DW-1:0] r_data  [STAGES];

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < STAGES; i++) begin
            r_valid[i] <= 1'b0;
            r_data[i]  <= '0;
          end
        end else begin
          r_valid[0] <= i_valid;
          if (i_valid) r_data[0] <= i_data;
          for (int i = 1; i < STAGES; i++) begin
            r_valid[i] <= r_valid[i-1];
            if (r_valid[i-1]) r_data[i] <= r_data[i-1];
          end
        end
      end

      assign o_valid = r_valid[STAGES-1];
      assign o_data  = r_data[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/matmul_mem_resp.sv
// Memory responder for the matmul bus: single-port word array, fixed-latency reads,
// a preload port that yields to bus writes, sticky out-of-range flag and activity counters.
module matmul_mem_resp
  import matmul_mem_resp_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF,
  parameter int MEM_DW = MEM_DW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mem_req,
  input  logic              i_mem_write,
  input  logic [MEM_AW-1:0] i_mem_addr,
  input  logic [MEM_DW-1:0] i_mem_wdata,
  output logic [MEM_DW-1:0] o_mem_rdata,
  output logic              o_mem_rvalid,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [MEM_AW-1:0] i_ld_addr,
  input  logic [MEM_DW-1:0] i_ld_data,
  output logic              o_err_oor,
  output logic [CNT_W-1:0]  o_rd_count,
  output logic [CNT_W-1:0]  o_wr_count
);

  localparam int RD_LAT_EFF = clamp_rd_lat(RD_LAT);
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [MEM_AW:0] DEPTH_EXT = (MEM_AW+1)'(DEPTH);

  logic [MEM_DW-1:0] r_mem [DEPTH];

  logic              w_busRd;
  logic              w_busWr;
  logic              w_busInRange;
  logic              w_ldInRange;
  logic              w_ldXfer;
  logic              w_oorHit;
  wsrc_e             w_wrSrc;
  logic [IDX_W-1:0]  w_wrIdx;
  logic [MEM_DW-1:0] w_wrData;
  logic [IDX_W-1:0]  w_rdIdx;

  logic              r_s1Valid;
  logic [MEM_DW-1:0] r_s1Data;
  logic              r_errOor;
  logic [CNT_W-1:0]  r_rdCount;
  logic [CNT_W-1:0]  r_wrCount;

  assign w_busRd      = i_mem_req & ~i_mem_write;
  assign w_busWr      = i_mem_req &  i_mem_write;
  assign w_busInRange = {1'b0, i_mem_addr} < DEPTH_EXT;
  assign w_ldInRange  = {1'b0, i_ld_addr}  < DEPTH_EXT;
  assign o_ld_ready   = ~w_busWr;
  assign w_ldXfer     = i_ld_valid & o_ld_ready;
  assign w_rdIdx      = i_mem_addr[IDX_W-1:0];
  assign w_oorHit     = (i_mem_req & ~w_busInRange) | (w_ldXfer & ~w_ldInRange);

  // A bus write always owns the write port; the preload only gets it when the bus is not writing.
  always_comb begin
    w_wrSrc  = WSRC_NONE;
    w_wrIdx  = '0;
    w_wrData = '0;
    if (w_busWr) begin
      if (w_busInRange) begin
        w_wrSrc  = WSRC_BUS;
        w_wrIdx  = i_mem_addr[IDX_W-1:0];
        w_wrData = i_mem_wdata;
      end
    end else if (w_ldXfer && w_ldInRange) begin
      w_wrSrc  = WSRC_LOAD;
      w_wrIdx  = i_ld_addr[IDX_W-1:0];
      w_wrData = i_ld_data;
    end
  end

  // Array contents survive reset; only the control state is cleared.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (w_wrSrc != WSRC_NONE)) begin
      r_mem[w_wrIdx] <= w_wrData;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1Valid <= 1'b0;
      r_s1Data  <= '0;
    end else begin
      r_s1Valid <= w_busRd;
      if (w_busRd) begin
        r_s1Data <= w_busInRange ? r_mem[w_rdIdx] : '0;
      end
    end
  end

  matmul_mem_resp_rd_pipe #(
    .DW     (MEM_DW),
    .STAGES (RD_LAT_EFF - 1)
  ) u_rdPipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (r_s1Valid),
    .i_data  (r_s1Data),
    .o_valid (o_mem_rvalid),
    .o_data  (o_mem_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_errOor  <= 1'b0;
      r_rdCount <= '0;
      r_wrCount <= '0;
    end else begin
      if (w_oorHit) r_errOor <= 1'b1;
      if (w_busRd && !(&r_rdCount)) r_rdCount <= r_rdCount + CNT_W'(1);
      if (w_busWr && !(&r_wrCount)) r_wrCount <= r_wrCount + CNT_W'(1);
    end
  end

  assign o_err_oor  = r_errOor;
  assign o_rd_count = r_rdCount;
  assign o_wr_count = r_wrCount;

endmodule
